// File: rtl/intermediate_write.sv
// 64-bit word to byte-stream serializer, MSB byte first, with a one-word pending
// buffer so back-to-back words stream without idle cycles.
//
// state | meaning
// IDLE  | nothing to send, data_valid_o low
// SEND  | shift register holds the current word, data_o = its top byte
module intermediate_write #(
    parameter int WORD_BITS = 64,
    parameter int BYTE_BITS = 8,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] word_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    output logic [BYTE_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 last_o,
    output logic [CNT_BITS-1:0]  word_count_o
);

    localparam int BYTES_PER_WORD = WORD_BITS / BYTE_BITS;
    localparam int IDX_BITS       = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BYTES_PER_WORD - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                state, state_n;
    logic [WORD_BITS-1:0]  sh, sh_n;
    logic [WORD_BITS-1:0]  pw, pw_n;
    logic [IDX_BITS-1:0]   idx, idx_n;
    logic                  pend_full, pend_full_n;
    logic [CNT_BITS-1:0]   word_count, word_count_n;
    logic                  word_accept, byte_xfer, last_xfer;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sh         <= '0;
            pw         <= '0;
            idx        <= '0;
            pend_full  <= 1'b0;
            word_count <= '0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            pw         <= pw_n;
            idx        <= idx_n;
            pend_full  <= pend_full_n;
            word_count <= word_count_n;
        end
    end

    // Ready comes from registers only, so a producer may wait on it before raising valid.
    assign word_ready_o = reset && !pend_full;
    assign data_valid_o = (state == SEND);
    assign data_o       = (state == SEND) ? sh[WORD_BITS-1 -: BYTE_BITS] : '0;
    assign last_o       = (state == SEND) && (idx == LAST_IDX);
    assign word_count_o = word_count;

    always_comb begin
        state_n      = state;
        sh_n         = sh;
        pw_n         = pw;
        idx_n        = idx;
        pend_full_n  = pend_full;
        word_count_n = word_count;
        word_accept  = word_valid_i && word_ready_o;
        byte_xfer    = data_valid_o && data_ready_i;
        last_xfer    = byte_xfer && (idx == LAST_IDX);

        case (state)
            IDLE: begin
                if (word_accept) begin
                    sh_n    = word_i;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (byte_xfer && !last_xfer) begin
                    sh_n  = sh << BYTE_BITS;
                    idx_n = idx + IDX_BITS'(1);
                end else if (last_xfer) begin
                    word_count_n = word_count + CNT_BITS'(1);
                    if (pend_full) begin
                        sh_n        = pw;
                        pend_full_n = 1'b0;
                        idx_n       = '0;
                    end else if (word_accept) begin
                        sh_n  = word_i;
                        idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
                // A word arriving mid-word parks in the pending buffer.
                if (word_accept && !last_xfer) begin
                    pw_n        = word_i;
                    pend_full_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
